// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin resource arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request after last.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(last) + i) % N;
            if (!found && req[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter with held grants, hold budget and one idle gap cycle.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_done,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             rel_done, rel_req, rel_tmo;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign rel_done = i_done & busy_q;
    assign rel_req  = ~i_req[idx_q];
    assign rel_tmo  = (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    last_d          = pick_idx;
                    hold_d          = '0;
                    busy_d          = 1'b1;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_req || rel_tmo) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    tmo_d   = rel_tmo & ~rel_done & ~rel_req;
                    state_d = GAP;
                end
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(N - 1);
            hold_q  <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;
    assign o_busy    = busy_q;
    assign o_timeout = tmo_q;

endmodule

// File: doc/rr_resource_arbiter.md
# rr_resource_arbiter

Round-robin arbiter that shares one downstream resource among `N` requesters with exclusive, held grants. A grant persists until the owner signals completion, withdraws its request, or exceeds a hold budget. There is one guaranteed idle cycle between owners. The block sits between requesting agents and a single-ported shared unit, and all ports are declared in the module header (ANSI style).

## Interface
Parameters:
- `N`, 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner; must be ≥ 1.
- `IDX_W`, `$clog2(N)`: width of the grant index (derived).

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `i_req`  input  N  per-requester request level.
- `i_done`  input  1  current owner finished; qualified by `o_busy`.
- `o_gnt`  output  N  one-hot grant, or all zero; registered.
- `o_gnt_idx`  output  IDX_W  index of the current owner; valid only while `o_busy`.
- `o_busy`  output  1  high while any grant is held (OR of `o_gnt`).
- `o_timeout`  output  1  one-cycle pulse when a grant is revoked by the hold budget.

## Operation
FSM states: `IDLE`, `GRANT`, `GAP`.

- **IDLE:**
  - If `i_req` ≠ 0, pick the first set bit scanning upward (cyclically) from `last+1`, where `last` is the previous owner.
  - Register `o_gnt`, `o_gnt_idx` and `last` ← picked index, clear `hold_cnt`, and go to `GRANT`.
  - If `i_req` = 0, stay in `IDLE`.
- **GRANT:** `hold_cnt` increments each cycle while in this state. Release occurs when any of the following holds:
  - (a) `i_done` = 1;
  - (b) `i_req[o_gnt_idx]` = 0;
  - (c) `hold_cnt` = `MAX_HOLD`-1.

  On release, clear `o_gnt` and go to `GAP`. `o_timeout` pulses only when (c) holds and neither (a) nor (b) holds.
- **GAP:** outputs are held at zero for exactly one cycle, then the FSM goes to `IDLE`. Requests sampled during `GAP` are ignored.

Rules:
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`. It saturates and never wraps.
- With `MAX_HOLD`=1, every grant lasts exactly one cycle.
- `last` wraps from N-1 to 0. Priority rotates only when a grant is issued.
- Requests from non-owners during `GRANT` do not affect the current grant.

Reset:
- All outputs are 0 and the state is `IDLE`.
- `last` resets to N-1, so index 0 has first priority.
- Reset asserted mid-grant drops `o_gnt` at the next edge. There is no `o_timeout` pulse and no completion event.

## Timing
- Request-to-grant latency: `i_req` sampled at edge t gives `o_gnt` high after edge t+1 (1 cycle).
- Release: condition sampled at edge t gives `o_gnt` low after edge t+1.
  - Earliest next grant is after edge t+2 (`GAP`) plus 1 (`IDLE`) — 2 dead cycles.
  - Back-to-back owner throughput is therefore one grant per (hold + 2) cycles.
- `o_timeout` is asserted in the same cycle that `o_gnt` first reads zero.
- Combinational paths from inputs to outputs are forbidden. All outputs come directly from flops.

## Structure
- Shared package `arb_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t`;
  - a localparam default for `MAX_HOLD`.
- Sub-module `rr_pick`: a purely combinational rotating priority picker.
  - Inputs: `req[N]` and `last[IDX_W]`.
  - Outputs: `found`, `idx`.
- The top level contains the FSM, hold counter and output registers.

## Test plan
- **Reset priority:** after reset, drive `i_req`=4'b1111 → `o_gnt`=0001 one cycle later, with `o_gnt_idx`=0.
- **Rotation:** keep all requests high and pulse `i_done` each grant → grant sequence 0,1,2,3,0. There are 2 zero cycles between grants.
- **Timeout:** `MAX_HOLD`=4, single requester 2 holds its request and never sets `i_done`:
  - `o_gnt`=0100 for exactly 4 cycles;
  - `o_timeout`=1 on the next cycle;
  - requester 2 is regranted after `GAP`/`IDLE`.
- **Simultaneous release:** `i_done`=1 in the same cycle `hold_cnt` reaches `MAX_HOLD`-1 → grant released and `o_timeout` stays 0.
- **Request withdrawal:** owner 1 drops `i_req[1]` mid-grant while 3 is pending → `o_gnt` drops next cycle, then `o_gnt`=1000.
- **Reset mid-grant:** `rst` pulsed while `o_gnt`=0010 → all outputs are 0 next cycle. With `i_req`=1111, the next grant is index 0.
